// File: rtl/iter_serial_eval_pkg.sv
// Shared definitions for the serial P/Q chain evaluator:
// FSM state encodings and a constant clog2 helper for sizing the step counter.
package iter_serial_eval_pkg;

  // Encoding 2'd3 is never produced; the FSM decodes it back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2 for elaboration-time sizing (value >= 2 in practice).
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 32'sd1;
    while (v > 32'sd0) begin
      result = result + 32'sd1;
      v = v >>> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/iter_serial_eval_step.sv
// One cell of the P/Q chain, purely combinational:
//   P' = x ? Q : P
//   Q' = !x | (P & Q)
module iter_serial_eval_step (
  input  logic x,
  input  logic p,
  input  logic q,
  output logic p_next,
  output logic q_next
);

  // Single chain step evaluated for the bit currently at the shift register head.
  always_comb begin
    p_next = 1'b0;
    q_next = 1'b0;
    if (x) begin
      p_next = q;
    end else begin
      p_next = p;
    end
    q_next = (~x) | (p & q);
  end

endmodule

// File: rtl/iter_serial_eval.sv
// Serial driver/evaluator for the P/Q iterative chain.
// A WIDTH-bit word is taken through a valid/ready handshake, shifted through a
// single registered step one bit per clock, and the final P/Q is presented on a
// second valid/ready handshake. No overlap: a new word is accepted only in IDLE.
// Optional build macro: ITER_ABORT_EN adds the abort input, which returns the
// block to IDLE from RUN or DONE without touching p_res/q_res.
module iter_serial_eval
  import iter_serial_eval_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_word,
  input  logic             p0,
  input  logic             q0,
`ifdef ITER_ABORT_EN
  input  logic             abort,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             p_res,
  output logic             q_res
);

  localparam int CNT_W = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_r;
  logic             p_r;
  logic             q_r;
  logic [WIDTH-1:0] shift_r;
  logic [CNT_W-1:0] cnt_r;
  logic             head_s;
  logic             p_step_s;
  logic             q_step_s;
  logic             abort_s;

`ifdef ITER_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign head_s = MSB_FIRST ? shift_r[WIDTH-1] : shift_r[0];

  iter_serial_eval_step u_step (
    .x      (head_s),
    .p      (p_r),
    .q      (q_r),
    .p_next (p_step_s),
    .q_next (q_step_s)
  );

  // Ready is a pure decode of the state so it is high while reset is held.
  always_comb begin
    in_ready = 1'b0;
    if ((state_r == ST_RUN) || (state_r == ST_DONE)) begin
      in_ready = 1'b0;
    end else begin
      in_ready = 1'b1;
    end
  end

  // Sequencer, shift/step datapath and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      p_r       <= 1'b0;
      q_r       <= 1'b0;
      shift_r   <= '0;
      cnt_r     <= '0;
      out_valid <= 1'b0;
      p_res     <= 1'b0;
      q_res     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            shift_r <= x_word;
            p_r     <= p0;
            q_r     <= q0;
            cnt_r   <= '0;
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort_s) begin
            state_r <= ST_IDLE;
          end else begin
            p_r     <= p_step_s;
            q_r     <= q_step_s;
            shift_r <= MSB_FIRST ? (shift_r << 1'b1) : (shift_r >> 1'b1);
            cnt_r   <= cnt_r + CNT_W'(1);
            if (cnt_r == CNT_LAST) begin
              // The final step result goes straight into the output registers.
              state_r   <= ST_DONE;
              out_valid <= 1'b1;
              p_res     <= p_step_s;
              q_res     <= q_step_s;
            end
          end
        end
        ST_DONE: begin
          // Abort and acceptance both leave DONE for IDLE; never reload here.
          if (abort_s || out_ready) begin
            state_r   <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
